// File: rtl/spi_frame_deserializer_if.sv
// Frame handshake bundle between the SPI frame deserializer (master side,
// produces frames) and the request queue (slave side, consumes frames).
interface spi_frame_deserializer_if #(
  parameter int OPW   = 2,
  parameter int ADDRW = 23
);
  logic             ready_in;
  logic             valid_out;
  logic [OPW-1:0]   opcode_out;
  logic [ADDRW-1:0] addr_out;

  modport master (
    input  ready_in,
    output valid_out,
    output opcode_out,
    output addr_out
  );

  modport slave (
    output ready_in,
    input  valid_out,
    input  opcode_out,
    input  addr_out
  );
endinterface

// File: rtl/spi_frame_deserializer.sv
// SPI receive-side frame deserializer: oversamples spi_clk/n_cs/mosi on clk,
// collects one {opcode, addr} frame per chip-select assertion and offers it
// on a valid/ready handshake. Malformed, aborted or overrun frames are
// dropped with a one-cycle err pulse.
// Optional build macro PARITY_CHECK_EN: adds a trailing even-parity bit to
// each frame; frames failing parity are dropped with err.
module spi_frame_deserializer #(
  parameter int OPW   = 2,
  parameter int ADDRW = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_clk,
  input  logic                    n_cs,
  input  logic                    mosi,
  spi_frame_deserializer_if.master fr,
  output logic                    err,
  output logic                    busy
);
  localparam int FRAME_W = OPW + ADDRW;
  localparam int CW      = $clog2(FRAME_W + 2);
`ifdef PARITY_CHECK_EN
  localparam int FRAME_BITS = FRAME_W + 1;
`else
  localparam int FRAME_BITS = FRAME_W;
`endif
  // Count value present on the rise that carries the final frame bit.
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] DATA_CNT = CW'(FRAME_W);

  typedef enum logic [1:0] {IDLE, RX, DRAIN} state_t;

  state_t             state;
  logic [1:0]         sclk_sync;
  logic [1:0]         cs_sync;
  logic [1:0]         mosi_sync;
  logic               sclk_d;
  logic [FRAME_W-1:0] sr;
  logic [CW-1:0]      cnt;
  logic               valid_q;
  logic [OPW-1:0]     opcode_q;
  logic [ADDRW-1:0]   addr_q;
  logic               err_q;

  logic               rise;
  logic               cs_act;
  logic               bit_in;
  logic [FRAME_W-1:0] sr_shift;
  logic [FRAME_W-1:0] frame_data;
  logic               frame_ok;
  logic               can_load;

  // Two-flop synchronisers plus one delay stage for spi_clk edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      cs_sync   <= {cs_sync[0], n_cs};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
    end
  end

  assign rise     = sclk_sync[1] & ~sclk_d;
  assign cs_act   = ~cs_sync[1];
  assign bit_in   = mosi_sync[1];
  assign sr_shift = {sr[FRAME_W-2:0], bit_in};
  assign can_load = ~valid_q | fr.ready_in;

`ifdef PARITY_CHECK_EN
  // Data register is already full when the parity bit arrives.
  assign frame_data = sr;
  assign frame_ok   = ~(^{sr, bit_in});
`else
  assign frame_data = sr_shift;
  assign frame_ok   = 1'b1;
`endif

  // Frame FSM with registered handshake outputs and err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      valid_q  <= 1'b0;
      opcode_q <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (valid_q && fr.ready_in) begin
        valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cs_act) begin
            state <= RX;
            cnt   <= '0;
            sr    <= '0;
          end
        end
        RX: begin
          if (!cs_act) begin
            // Select released before the frame completed: drop partial data.
            state <= IDLE;
            if (cnt != '0) begin
              err_q <= 1'b1;
            end
          end else if (rise) begin
            cnt <= cnt + 1'b1;
            if (cnt < DATA_CNT) begin
              sr <= sr_shift;
            end
            if (cnt == LAST_IDX) begin
              state <= DRAIN;
              if (!frame_ok) begin
                err_q <= 1'b1;
              end else if (can_load) begin
                // Reload also covers acceptance in this same cycle: no bubble.
                valid_q  <= 1'b1;
                opcode_q <= frame_data[FRAME_W-1:ADDRW];
                addr_q   <= frame_data[ADDRW-1:0];
              end else begin
                // Previous frame still pending: overrun, keep held outputs.
                err_q <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (!cs_act) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fr.valid_out  = valid_q;
  assign fr.opcode_out = opcode_q;
  assign fr.addr_out   = addr_q;
  assign err           = err_q;
  assign busy          = (state == RX);

endmodule
